// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and the dmem_responder.
// Each channel transfers on a posedge where valid && ready; valid never waits on ready.
interface dmem_responder_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Big-endian byte-wide data memory behind a request/response handshake with WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN rejects unaligned accesses with rsp_err instead of wrapping.
module dmem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DEPTH_BYTES = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              accept, access;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              acc_write, misaligned;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       acc_wdata;
  logic [31:0]       rdata;
  logic              err;
  logic [7:0]        mem [DEPTH_BYTES];

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign state_dbg     = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end else begin
            access     = 1'b1;
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, straight from the bus.
  always_comb begin
    acc_write = cap_write;
    a0        = cap_addr;
    acc_wdata = cap_wdata;
    if (state == S_IDLE) begin
      acc_write = bus.req_write;
      a0        = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  // Byte addresses wrap naturally because DEPTH_BYTES == 2**ADDR_W.
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (a0[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (access) begin
        err   <= misaligned;
        rdata <= (acc_write || misaligned) ? 32'h0 : {mem[a0], mem[a1], mem[a2], mem[a3]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= bus.req_write;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
    end
  end

  // Storage is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && access && acc_write && !misaligned) begin
      mem[a0] <= acc_wdata[31:24];
      mem[a1] <= acc_wdata[23:16];
      mem[a2] <= acc_wdata[15:8];
      mem[a3] <= acc_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: one instance with 1 wait state, one with 3.
module tb_dmem_responder;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic clk;
  logic rst1_n, rst3_n;
  logic [1:0] st1, st3;
  int cyc;
  int n_checks, n_fail;
  logic [48:0] q1[$];
  logic [48:0] q3[$];
  bit pv1, pv3;

  dmem_responder_if #(.ADDR_W(5)) b1();
  dmem_responder_if #(.ADDR_W(5)) b3();

  dmem_responder #(.ADDR_W(5), .DEPTH_BYTES(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1.slave), .state_dbg(st1)
  );
  dmem_responder #(.ADDR_W(5), .DEPTH_BYTES(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3.slave), .state_dbg(st3)
  );

  // clock / cycle count / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: response present with no expected entry", name);
  endtask

  // monitors: first-valid latency, then rdata/err each cycle valid is up (covers stability), pop on handshake
  always @(negedge clk) begin
    if (b1.rsp_valid) begin
      if (q1.size() == 0) fail_now("dut1_unexpected_rsp");
      else begin
        if (!pv1) check("dut1_latency", 32'(cyc[15:0]), 32'(q1[0][48:33]));
        check("dut1_rdata", b1.rsp_rdata, q1[0][31:0]);
        check("dut1_err", 32'(b1.rsp_err), 32'(q1[0][32]));
        if (b1.rsp_ready) void'(q1.pop_front());
      end
    end
    pv1 = b1.rsp_valid;
  end

  always @(negedge clk) begin
    if (b3.rsp_valid) begin
      if (q3.size() == 0) fail_now("dut3_unexpected_rsp");
      else begin
        if (!pv3) check("dut3_latency", 32'(cyc[15:0]), 32'(q3[0][48:33]));
        check("dut3_rdata", b3.rsp_rdata, q3[0][31:0]);
        check("dut3_err", 32'(b3.rsp_err), 32'(q3[0][32]));
        if (b3.rsp_ready) void'(q3.pop_front());
      end
    end
    pv3 = b3.rsp_valid;
  end

  // driver: present a request, wait (bounded) for acceptance, push the expected response
  task automatic issue(input bit sel, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       input bit push, input logic [31:0] exp_rd, input bit exp_err);
    bit got;
    int w;
    got = 1'b0;
    w = sel ? 3 : 1;
    @(posedge clk); #1;
    if (sel) begin
      b3.req_valid = 1'b1; b3.req_write = wr; b3.req_addr = a; b3.req_wdata = wd;
    end else begin
      b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = a; b1.req_wdata = wd;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = sel ? b3.req_ready : b1.req_ready;
    end
    check("req_accept_timeout", 32'(got), 32'd1);
    if (push) begin
      if (sel) q3.push_back({16'(cyc + 1 + w), exp_err, exp_rd});
      else     q1.push_back({16'(cyc + 1 + w), exp_err, exp_rd});
    end
    @(posedge clk); #1;
    if (sel) b3.req_valid = 1'b0;
    else     b1.req_valid = 1'b0;
  endtask

  task automatic wr(input bit sel, input logic [4:0] a, input logic [31:0] d, input bit exp_err);
    issue(sel, 1'b1, a, d, 1'b1, 32'h0, exp_err);
  endtask

  task automatic rd(input bit sel, input logic [4:0] a, input logic [31:0] exp, input bit exp_err);
    issue(sel, 1'b0, a, 32'h0, 1'b1, exp, exp_err);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (q1.size() == 0) && (q3.size() == 0) && b1.req_ready && b3.req_ready;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    bit seen;
    n_checks = 0; n_fail = 0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.rsp_ready = 1'b1;
    b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_addr = '0; b3.req_wdata = '0; b3.rsp_ready = 1'b1;
    rst1_n = 1'b0; rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(b1.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    check("rst_rsp_rdata", b1.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(b1.rsp_err), 32'd0);
    check("rst_state", 32'(st1), 32'd0);
    check("rst3_rsp_valid", 32'(b3.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst1_n = 1'b1; rst3_n = 1'b1;

    // basic write/read and unaligned read
    wr(0, 5'd0,  32'h00000000, 1'b0);
    wr(0, 5'd28, 32'h00000000, 1'b0);
    wr(0, 5'd8,  32'h11223344, 1'b0);
    rd(0, 5'd8,  32'h11223344, 1'b0);
    wr(0, 5'd12, 32'h55667788, 1'b0);
    rd(0, 5'd9,  AC ? 32'h0 : 32'h22334455, AC);

    // wrap-around write across the top of memory
    wr(0, 5'd30, 32'hAABBCCDD, AC);
    rd(0, 5'd0,  AC ? 32'h0 : 32'hCCDD0000, 1'b0);
    rd(0, 5'd28, AC ? 32'h0 : 32'h0000AABB, 1'b0);
    drain("drain_basic");

    // back-pressure: response held 5 cycles, a stray write must be ignored
    b1.rsp_ready = 1'b0;
    rd(0, 5'd8, 32'h11223344, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = b1.rsp_valid;
    end
    check("bp_valid_timeout", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = 5'd8; b1.req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("bp_req_ready", 32'(b1.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(b1.rsp_valid), 32'd1);
      check("bp_state", 32'(st1), 32'd2);
    end
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_valid", 32'(b1.rsp_valid), 32'd0);
    check("bp_after_ready", 32'(b1.req_ready), 32'd1);
    check("bp_one_handshake", 32'(q1.size()), 32'd0);
    rd(0, 5'd8, 32'h11223344, 1'b0);

    // misaligned write: rejected under the alignment check, otherwise a plain write
    wr(0, 5'd4, 32'h01020304, 1'b0);
    wr(0, 5'd2, 32'h12345678, AC);
    rd(0, 5'd4, AC ? 32'h01020304 : 32'h56780304, 1'b0);
    rd(0, 5'd0, AC ? 32'h0 : 32'hCCDD1234, 1'b0);
    drain("drain_align");

    // reset during WAIT on the 3-wait-state instance drops the write
    wr(1, 5'd4, 32'h01020304, 1'b0);
    issue(1, 1'b1, 5'd4, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midwait_no_rsp", 32'(b3.rsp_valid), 32'd0);
    end
    check("midwait_state", 32'(st3), 32'd0);
    rd(1, 5'd4, 32'h01020304, 1'b0);
    drain("drain_final");
    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q3_empty", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory port. Holds DEPTH_BYTES of byte-wide storage, big-endian: the byte at addr is the word's MSB and addr+3 is its LSB. It accepts one 32-bit read or write request at a time over a valid/ready handshake, inserts a configurable number of wait states, and returns a response over a second valid/ready handshake. It turns the combinational datmem access into a multi-cycle, back-pressured slave usable by a later multi-cycle or pipelined core.

Parameters:
ADDR_W, 5, byte-address width; DEPTH_BYTES must equal 2**ADDR_W
DEPTH_BYTES, 32, storage size in bytes
WAIT_CYCLES, 1, wait states between acceptance and the memory access (0..15)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address of the word's MSB
req_wdata  input  32  write data, bits [31:24] go to req_addr
rsp_valid  output  1  response present
rsp_ready  input  1  initiator takes the response
rsp_rdata  output  32  read data; 0 for write responses
rsp_err  output  1  error flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; req_ready=1 after the edge; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
  - Storage contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a posedge (acceptance edge t0), capture write/addr/wdata.
  - If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1; otherwise perform the access and go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each edge.
  - At the edge where counter==0, perform the access and go to RESP.
  - The access therefore occurs at edge t0+WAIT_CYCLES.
- Access (single edge):
  - Write: byte[a]=wdata[31:24], byte[a+1]=[23:16], byte[a+2]=[15:8], byte[a+3]=[7:0]; rsp_rdata<=0.
  - Read: rsp_rdata<={byte[a],byte[a+1],byte[a+2],byte[a+3]}, sampled before any write at that edge.
  - Address arithmetic is modulo DEPTH_BYTES: an address of DEPTH_BYTES-1 wraps to bytes 31,0,1,2.
  - Unaligned addresses are legal unless ALIGN_CHECK_EN is defined.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready at a posedge: rsp_valid<=0, go to IDLE.
  - rsp_valid falls and req_ready rises in the same cycle, giving a one-cycle bubble minimum between responses.
- Latency: rsp_valid is first high in the cycle after edge t0+WAIT_CYCLES. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles with rsp_ready tied 1.
- Inputs req_* are ignored outside IDLE; only one outstanding request.
- Reset mid-operation:
  - In WAIT: the request is dropped and no write occurs.
  - In RESP: the response is dropped; a write already performed remains in storage.
- rsp_rdata/rsp_err hold their last values in IDLE; rsp_valid qualifies them.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0]!=0 is still accepted and still waits WAIT_CYCLES.
  - At the access edge, no storage is modified; rsp_rdata<=0 and rsp_err<=1.
  - Aligned requests return rsp_err=0.
- Undefined: rsp_err is tied 0; unaligned accesses proceed with modulo wrap as above.

Test Plan:
- Reset then idle: hold rst_n=0 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Write/read, WAIT_CYCLES=1: write addr 8, data 0x11223344 -> rsp_valid in cycle after edge t0+1, rdata 0. Then read addr 8 -> rdata 0x11223344. Read addr 9 (macro off) -> 0x223344xx, where xx=byte[12].
- Wrap-around: write addr 30, data 0xAABBCCDD (macro off) -> bytes 30,31,0,1 = AA,BB,CC,DD. Read addr 0 -> rdata[31:16]=0xCCDD.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rdata stable, req_ready=0, a new req_valid is ignored. Raising rsp_ready -> exactly one handshake, then IDLE.
- Reset mid-WAIT: WAIT_CYCLES=3, issue write 0xDEADBEEF to addr 4, assert rst_n=0 at edge t0+1 -> no response. A subsequent read of addr 4 returns the prior contents.
- DMEM_ALIGN_CHECK_EN defined: write addr 2, data 0x12345678 -> rsp_err=1, rdata 0, bytes 2..5 unchanged. Aligned read of addr 4 -> rsp_err=0.
